// File: rtl/elastic_pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline stage: default payload width and
// the FSM state type.
package elastic_pipe_reg_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic logic [1:0] state_count(state_e st);
    unique case (st)
      StOne:   return 2'd1;
      StFull:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_data_reg.sv
// Payload register with load, clear-to-reset-value and asynchronous reset.
module skid_data_reg #(
  parameter int unsigned          WIDTH      = 1,
  parameter logic [WIDTH-1:0]     RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a flush always leaves the reset payload behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_DATA;
    end else if (clear) begin
      q <= RESET_DATA;
    end else if (load) begin
      q <= load_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Two-entry elastic pipeline stage (skid buffer) with valid/ready on both sides,
// synchronous flush and a configurable payload shown while empty.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH      = XLEN,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_e           state_q, state_d;
  logic             accept, drain;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic [WIDTH-1:0] main_next, skid_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_next  = in_data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = StEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = StEmpty;
          end
        end
        StFull: begin
          if (drain) begin
            main_load  = 1'b1;
            main_next  = skid_q;
            skid_clear = 1'b1;
            state_d    = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so ready never sees out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != StFull);
      out_valid <= (state_d != StEmpty);
      count     <= state_count(state_d);
    end
  end

  skid_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_next),
    .q         (out_data)
  );

  skid_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .q         (skid_q)
  );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios on a 32-bit instance and a
// randomized queue-model run shared by 1-bit and 64-bit instances.
module tb_elastic_pipe_reg;

  localparam logic [31:0] RD32 = 32'h0000_0013;
  localparam logic [63:0] RD64 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [0:0]  RD1  = 1'b1;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        ir32, ov32, ir64, ov64, ir1, ov1;
  logic [31:0] od32;
  logic [63:0] od64;
  logic [0:0]  od1;
  logic [1:0]  cnt32, cnt64, cnt1;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(32), .RESET_DATA(RD32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_data(in_data[31:0]), .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
    .count(cnt32)
  );

  elastic_pipe_reg #(.WIDTH(64), .RESET_DATA(RD64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_data(in_data), .out_valid(ov64), .out_ready(out_ready), .out_data(od64),
    .count(cnt64)
  );

  elastic_pipe_reg #(.WIDTH(1), .RESET_DATA(RD1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data[0:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(cnt1)
  );

  // Queue model: a stage holds at most two payloads, first in first out.
  task automatic model_step(input logic acc, input logic drn, input logic fl,
                            input logic [63:0] d);
    if (fl) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    total++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || od32 !== RD32 || cnt32 !== 2'd0) begin
      bad++;
      $display("FAIL reset: got v=%b r=%b d=%h c=%0d want v=0 r=1 d=%h c=0",
               ov32, ir32, od32, cnt32, RD32);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i > 1) begin
        total++;
        if (ov32 !== 1'b1 || od32 !== 32'(i - 1) || cnt32 !== 2'd1 || ir32 !== 1'b1) begin
          bad++;
          $display("FAIL stream[%0d]: got v=%b d=%h c=%0d r=%b want v=1 d=%h c=1 r=1",
                   i - 1, ov32, od32, cnt32, ir32, 32'(i - 1));
        end
      end
      in_valid = (i <= 8);
      in_data  = 64'(i);
    end
    @(negedge clk);
    total++;
    if (ov32 !== 1'b0 || od32 !== RD32 || cnt32 !== 2'd0) begin
      bad++;
      $display("FAIL stream_end: got v=%b d=%h c=%0d want v=0 d=%h c=0", ov32, od32, cnt32, RD32);
    end
  endtask

  task automatic test_skid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    @(negedge clk);
    in_data = 64'hB;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd2 || ir32 !== 1'b0 || od32 !== 32'hA) begin
      bad++;
      $display("FAIL skid_full: got c=%0d r=%b d=%h want c=2 r=0 d=a", cnt32, ir32, od32);
    end
    in_data = 64'hC;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd2 || od32 !== 32'hA) begin
      bad++;
      $display("FAIL skid_ignore: got c=%0d d=%h want c=2 d=a", cnt32, od32);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd1 || od32 !== 32'hB || ir32 !== 1'b1) begin
      bad++;
      $display("FAIL skid_drain_b: got c=%0d d=%h r=%b want c=1 d=b r=1", cnt32, od32, ir32);
    end
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd1 || od32 !== 32'hC) begin
      bad++;
      $display("FAIL skid_c: got c=%0d d=%h want c=1 d=c", cnt32, od32);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd0 || ov32 !== 1'b0 || od32 !== RD32) begin
      bad++;
      $display("FAIL skid_empty: got c=%0d v=%b d=%h want c=0 v=0 d=%h", cnt32, ov32, od32, RD32);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1;
    @(negedge clk) in_data = 64'h2;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd2) begin
      bad++;
      $display("FAIL flush_fill: got c=%0d want c=2", cnt32);
    end
    flush = 1'b1; in_data = 64'hD;
    @(negedge clk);
    total++;
    if (cnt32 !== 2'd0 || ov32 !== 1'b0 || od32 !== RD32 || ir32 !== 1'b1) begin
      bad++;
      $display("FAIL flush: got c=%0d v=%b d=%h r=%b want c=0 v=0 d=%h r=1",
               cnt32, ov32, od32, ir32, RD32);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ov32 !== 1'b0 || od32 !== RD32) begin
        bad++;
        $display("FAIL flush_no_d[%0d]: got v=%b d=%h want v=0 d=%h", i, ov32, od32, RD32);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h5;
    @(negedge clk) in_data = 64'h6;
    @(negedge clk) in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (cnt32 !== 2'd0 || ov32 !== 1'b0 || od32 !== RD32 || ir32 !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got c=%0d v=%b d=%h r=%b want c=0 v=0 d=%h r=1",
               cnt32, ov32, od32, ir32, RD32);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hE;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (ov32 !== 1'b1 || od32 !== 32'hE || cnt32 !== 2'd1) begin
      bad++;
      $display("FAIL after_reset: got v=%b d=%h c=%0d want v=1 d=e c=1", ov32, od32, cnt32);
    end
    @(negedge clk);
    total++;
    if (ov32 !== 1'b0 || od32 !== RD32) begin
      bad++;
      $display("FAIL after_reset_empty: got v=%b d=%h want v=0 d=%h", ov32, od32, RD32);
    end
  endtask

  task automatic test_random();
    logic        exp_v, exp_r, acc, drn;
    logic [63:0] exp_d;
    @(negedge clk) reset = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk) reset = 1'b0;
    mq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      exp_v = (mq.size() > 0);
      exp_r = (mq.size() < 2);
      exp_d = exp_v ? mq[0] : RD64;
      total++;
      if (ov64 !== exp_v || ir64 !== exp_r || cnt64 !== 2'(mq.size()) || od64 !== exp_d) begin
        bad++;
        $display("FAIL rand64[%0d]: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                 cyc, ov64, ir64, cnt64, od64, exp_v, exp_r, mq.size(), exp_d);
      end
      total++;
      if (ov1 !== exp_v || ir1 !== exp_r || cnt1 !== 2'(mq.size())
          || od1 !== (exp_v ? mq[0][0:0] : RD1)) begin
        bad++;
        $display("FAIL rand1[%0d]: got v=%b r=%b c=%0d d=%b want v=%b r=%b c=%0d",
                 cyc, ov1, ir1, cnt1, od1, exp_v, exp_r, mq.size());
      end
      // Upstream holds its payload until accepted.
      if (!(in_valid && !exp_r)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      acc = in_valid & exp_r;
      drn = exp_v & out_ready;
      @(posedge clk);
      model_step(acc, drn, flush, in_data);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
